// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and bit-timing helpers
//
// Contents:
//   rx_state_t        receiver FSM state encoding
//   clks_per_bit()    clocks per serial bit (integer division)
//   half_bit()        clocks from start-bit edge to start-bit centre
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_bit(input int clk_freq, input int baud_rate);
        return clks_per_bit(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
//
// Ports:
//   clk     in   destination clock
//   rst_n   in   asynchronous active-low reset, both flops load RST_VAL
//   i_d     in   asynchronous input
//   o_q     out  synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output and error pulses
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data_out   out  last received byte, LSB first on the wire
//   valid      out  data_out holds an unconsumed byte
//   ready      in   consumer takes data_out when valid && ready
//   busy       out  a frame is in progress
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, completed byte dropped while valid held
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic             w_rx_s;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             w_stop_sample;
    logic             w_byte_done;
    logic             w_frame_bad;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (rx),
        .o_q  (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_stop_sample = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line at the start-bit centre; a high level here
                // was a glitch and the frame is silently dropped.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                // Leave at the stop-bit centre so the next start edge is seen
                // even when frames arrive back to back.
                if (r_cnt == FULL_LAST) begin
                    w_cnt_nxt     = '0;
                    w_stop_sample = 1'b1;
                    w_state_nxt   = RX_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_byte_done = w_stop_sample & w_rx_s;
    assign w_frame_bad = w_stop_sample & ~w_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= 1'b0;
            if (w_byte_done) begin
                // A byte consumed in the same cycle frees the holding register.
                if (!r_valid || ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != RX_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int BIT = 16;
    // Stop-bit centre sits 9.5 bits after the start edge, plus synchronizer delay.
    localparam int LAT_MIN = 9 * BIT + 6;
    localparam int LAT_MAX = 10 * BIT + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_FREQ (16),
        .BAUD_RATE(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Consumer-side observer: every handshake delivers one byte.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic       prev_ovr   = 1'b0;
    int         rise_cnt   = 0;
    int         last_rise  = 0;
    int         ferr_cnt   = 0;
    int         ovr_cnt    = 0;
    int         wide_cnt   = 0;

    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            rise_cnt++;
            last_rise = cyc;
        end
        if (valid && ready && rst_n) got_q.push_back(data_out);
        if (frame_err) begin
            if (prev_ferr) wide_cnt++;
            else ferr_cnt++;
        end
        if (overrun) begin
            if (prev_ovr) wide_cnt++;
            else ovr_cnt++;
        end
        prev_valid = valid;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok, output int start);
        start = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(stop_ok, BIT);
        if (!stop_ok) hold(1'b1, BIT);
    endtask

    task automatic check_latency(input string tag, input int start);
        int d;
        d = last_rise - start;
        check(tag, (d >= LAT_MIN && d <= LAT_MAX), 1);
    endtask

    int s;
    int r0;
    int exp_ferr = 0;
    int exp_ovr  = 0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        hold(1'b1, 4);

        // Single byte, consumer always ready.
        ready = 1'b1;
        r0 = rise_cnt;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, s);
        hold(1'b1, BIT);
        check_latency("a5_latency", s);
        check("a5_rises", rise_cnt - r0, 1);
        check("a5_data", data_out, 8'hA5);
        check_q("a5_bytes");
        check("a5_ferr", ferr_cnt, exp_ferr);
        check("a5_ovr", ovr_cnt, exp_ovr);

        // Short low glitch is rejected at the start-bit centre.
        r0 = rise_cnt;
        hold(1'b0, 5);
        check("glitch_busy_hi", busy, 1);
        rx = 1'b1;
        for (int i = 0; i < 40 && busy; i++) hold(1'b1, 1);
        check("glitch_busy_lo", busy, 0);
        check("glitch_rises", rise_cnt - r0, 0);
        check("glitch_ferr", ferr_cnt, exp_ferr);
        check_q("glitch_bytes");

        // Bad stop bit.
        r0 = rise_cnt;
        exp_ferr++;
        send(8'h3C, 1'b0, s);
        check("ferr_count", ferr_cnt, exp_ferr);
        check("ferr_rises", rise_cnt - r0, 0);
        check("ferr_valid", valid, 0);
        check("ferr_data", data_out, 8'hA5);

        // Overrun: second byte arrives while the first is still held.
        ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_ovr++;
        send(8'h11, 1'b1, s);
        send(8'h22, 1'b1, s);
        hold(1'b1, 4);
        check("ovr_count", ovr_cnt, exp_ovr);
        check("ovr_data", data_out, 8'h11);
        check("ovr_valid", valid, 1);
        ready = 1'b1;
        hold(1'b1, 1);
        check("ovr_valid_clr", valid, 0);
        check("ovr_data_kept", data_out, 8'h11);
        check_q("ovr_bytes");

        // Reset in the middle of the data bits of 8'hFF.
        hold(1'b0, BIT);
        hold(1'b1, 40);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        hold(1'b1, 2);
        rst_n = 1'b1;
        hold(1'b1, 4);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, s);
        hold(1'b1, BIT);
        check_latency("5a_latency", s);
        check_q("5a_bytes");

        // Back-to-back extremes.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'h00, 1'b1, s);
        send(8'hFF, 1'b1, s);
        hold(1'b1, BIT);
        check_q("b2b_bytes");
        check("b2b_ferr", ferr_cnt, exp_ferr);
        check("b2b_ovr", ovr_cnt, exp_ovr);

        // Random frames with occasional bad stop bits and random idle gaps.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            if (ok) exp_q.push_back(b);
            else exp_ferr++;
            send(b, ok, s);
            if (ok) check_latency("rnd_latency", s);
            hold(1'b1, $urandom_range(0, 40));
        end
        hold(1'b1, BIT);
        check_q("rnd_bytes");
        check("rnd_ferr", ferr_cnt, exp_ferr);
        check("rnd_ovr", ovr_cnt, exp_ovr);
        check("pulse_width", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  serial line, 8N1, idle high, asynchronous to clk.
REQ-006 data_out  output  8  last received byte, LSB = first data bit.
REQ-007 valid  output  1  data_out holds an unconsumed byte.
REQ-008 ready  input  1  consumer accepts data_out when valid && ready on a clk edge.
REQ-009 busy  output  1  high while a frame is being received (state != RX_IDLE).
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: completed byte dropped because valid was held.

Function
REQ-012 CLKS_PER_BIT SHALL be CLK_FREQ/BAUD_RATE (integer division); HALF_BIT SHALL be CLKS_PER_BIT/2.
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-014 FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-015 RX_IDLE: rx_s low -> RX_START, bit counter cleared to 0.
REQ-016 RX_START: after HALF_BIT cycles, rx_s low -> RX_DATA with data-bit index 0; rx_s high -> RX_IDLE (glitch rejected, no flags).
REQ-017 RX_DATA: every CLKS_PER_BIT cycles, sample rx_s into bit[index]; after the 8th sample (index 7) -> RX_STOP.
REQ-018 RX_STOP: after CLKS_PER_BIT cycles, sample rx_s and return to RX_IDLE in the same cycle (mid-stop-bit), so back-to-back frames are accepted.
REQ-019 Stop sample high: byte completes; stop sample low: frame_err pulses one cycle, byte discarded, valid unchanged.
REQ-020 Completed byte with valid low, or valid && ready that cycle: data_out loaded, valid high next cycle.
REQ-021 Completed byte with valid high and ready low: byte dropped, data_out unchanged, overrun pulses one cycle.
REQ-022 valid && ready without completion: valid cleared next cycle; data_out retains its value.
REQ-023 Latency: valid rises exactly 1 clk after the stop-bit sample edge.
REQ-024 Counters SHALL be sized $clog2(CLKS_PER_BIT)+1 bits; no wrap during a frame.

Reset
REQ-025 rst_n low SHALL immediately force: state RX_IDLE, counters 0, data_out 8'h00, valid 0, busy 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abandon the frame; reception resumes only on a fresh falling edge after rst_n deasserts.

Structure
REQ-027 Shared package uart_pkg SHALL hold the rx state enum and the CLKS_PER_BIT/HALF_BIT computation.
REQ-028 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value parameterized, set to 1 here).

Verification (CLK_FREQ=16, BAUD_RATE=1 -> 16 clks/bit)
REQ-029 Send 8'hA5, ready high -> valid one cycle, data_out=8'hA5, frame_err=0, overrun=0.
REQ-030 rx low for 5 clks then high -> returns to RX_IDLE, busy falls, no valid, no flags.
REQ-031 Send 8'h3C with stop bit low -> frame_err pulses once, valid stays 0, data_out unchanged.
REQ-032 Send 8'h11 then 8'h22 back-to-back, ready low -> data_out=8'h11 held, overrun pulses once at 2nd byte; ready high -> valid clears.
REQ-033 Assert rst_n low mid-RX_DATA of 8'hFF -> all outputs reset values; subsequent frame 8'h5A received correctly.
REQ-034 Send 8'h00 and 8'hFF back-to-back, ready high -> both bytes delivered in order, no flags.
